// File: rtl/bram_pwm_bank_if.sv
// BRAM port-B read bus between the PWM bank (master) and the block RAM (slave).
// Read strobe: bram_rd_en qualifies bram_addr in the same cycle, and bram_dout holds that word RD_LAT cycles later; there is no backpressure.
interface bram_pwm_bank_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_rd_en;
  logic [31:0]       bram_dout;

  modport master (output bram_addr, output bram_rd_en, input bram_dout);
  modport slave  (input bram_addr, input bram_rd_en, output bram_dout);
endinterface

// File: rtl/bram_pwm_bank.sv
// Multi-channel PWM bank. A background scanner fetches compare, enable and period words from a BRAM window into shadow registers.
// The shadow registers are committed atomically at a period wrap.
module bram_pwm_bank #(
  parameter int CH_NUM    = 10,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 8100,
  parameter int RD_LAT    = 2,
  parameter bit POL       = 1'b0
) (
  input  logic                  clk25,
  input  logic                  fpga_rst,
  bram_pwm_bank_if.master       bram,
  output logic [CH_NUM-1:0]     pwm_out,
  output logic                  period_tick,
  output logic                  update_tick,
  output logic [1:0]            dbg_state
);
  localparam int IDX_W = $clog2(CH_NUM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [RD_LAT-1:0]             tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;
  logic [CH_NUM-1:0][CNT_W-1:0]  cmp_sh_q, cmp_sh_d, cmp_act_q, cmp_act_d;
  logic [CH_NUM-1:0]             en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic [CNT_W-1:0]              per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          shadow_valid_q, shadow_valid_d;
  logic [CH_NUM-1:0]             pwm_q, pwm_d;
  logic                          period_tick_q, period_tick_d;
  logic                          update_tick_q, update_tick_d;

  logic                          rd_en;
  logic                          cap_vld, last_cap, wrap;
  logic [IDX_W-1:0]              cap_idx;
  logic [CNT_W-1:0]              cap_val;
  logic                          unused_dout_bits;

  assign cap_vld  = tag_vld_q[RD_LAT-1];
  assign cap_idx  = tag_idx_q[RD_LAT-1];
  assign cap_val  = bram.bram_dout[CNT_W-1:0];
  assign last_cap = cap_vld && (cap_idx == LAST_IDX);
  assign wrap     = (cnt_q == per_act_q);
  assign unused_dout_bits = ^bram.bram_dout[30:CNT_W];

  // Scanner FSM: state register
  always_ff @(posedge clk25) begin
    if (fpga_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Scanner FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (!shadow_valid_q) state_d = S_READ;
      end
      S_READ: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (last_cap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner FSM: outputs
  always_comb begin
    rd_en = (state_q == S_READ);
  end

  assign bram.bram_rd_en = rd_en;
  assign bram.bram_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
  assign dbg_state       = state_q;

  // Each issued index travels RD_LAT stages so it emerges alongside its read data.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = rd_en;
    tag_idx_d[0] = idx_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_comb begin
    cmp_sh_d       = cmp_sh_q;
    en_sh_d        = en_sh_q;
    per_sh_d       = per_sh_q;
    shadow_valid_d = shadow_valid_q;
    cmp_act_d      = cmp_act_q;
    en_act_d       = en_act_q;
    per_act_d      = per_act_q;
    update_tick_d  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cap_vld && (cap_idx == IDX_W'(i))) begin
        cmp_sh_d[i] = cap_val;
        en_sh_d[i]  = bram.bram_dout[31];
      end
    end
    if (last_cap) begin
      per_sh_d       = (cap_val == '0) ? '1 : cap_val;
      shadow_valid_d = 1'b1;
    end
    // A full shadow set is only ever handed over at the wrap, so a period never mixes old and new values.
    if (wrap && shadow_valid_q) begin
      cmp_act_d      = cmp_sh_q;
      en_act_d       = en_sh_q;
      per_act_d      = per_sh_q;
      shadow_valid_d = 1'b0;
      update_tick_d  = 1'b1;
    end
  end

  always_comb begin
    cnt_d         = wrap ? '0 : cnt_q + CNT_W'(1);
    period_tick_d = wrap;
    for (int i = 0; i < CH_NUM; i++) begin
      pwm_d[i] = (en_act_q[i] && (cnt_q < cmp_act_q[i])) ? POL : ~POL;
    end
  end

  always_ff @(posedge clk25) begin
    if (fpga_rst) begin
      tag_vld_q      <= '0;
      tag_idx_q      <= '0;
      cmp_sh_q       <= '0;
      en_sh_q        <= '0;
      per_sh_q       <= '1;
      shadow_valid_q <= 1'b0;
      cmp_act_q      <= '0;
      en_act_q       <= '0;
      per_act_q      <= '1;
      cnt_q          <= '0;
      pwm_q          <= {CH_NUM{~POL}};
      period_tick_q  <= 1'b0;
      update_tick_q  <= 1'b0;
    end else begin
      tag_vld_q      <= tag_vld_d;
      tag_idx_q      <= tag_idx_d;
      cmp_sh_q       <= cmp_sh_d;
      en_sh_q        <= en_sh_d;
      per_sh_q       <= per_sh_d;
      shadow_valid_q <= shadow_valid_d;
      cmp_act_q      <= cmp_act_d;
      en_act_q       <= en_act_d;
      per_act_q      <= per_act_d;
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_tick_q  <= period_tick_d;
      update_tick_q  <= update_tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;
  assign update_tick = update_tick_q;
endmodule

// File: tb/tb_bram_pwm_bank.sv
// Self-checking bench for bram_pwm_bank: BRAM read model, address and waveform scoreboards, boundary and reset scenarios.
module tb_bram_pwm_bank;
  localparam int CH_NUM    = 10;
  localparam int CNT_W     = 8;
  localparam int ADDR_W    = 13;
  localparam int BASE_ADDR = 8100;
  localparam int RD_LAT    = 2;
  localparam int VW        = CH_NUM + 2;

  // Clock / reset
  logic clk25    = 1'b0;
  logic fpga_rst = 1'b1;
  always #20 clk25 = ~clk25;

  logic [CH_NUM-1:0] pwm_out;
  logic              period_tick;
  logic              update_tick;
  logic [1:0]        dbg_state;

  bram_pwm_bank_if #(.ADDR_W(ADDR_W)) bif ();

  bram_pwm_bank #(
    .CH_NUM(CH_NUM), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .RD_LAT(RD_LAT), .POL(1'b0)
  ) dut (
    .clk25(clk25),
    .fpga_rst(fpga_rst),
    .bram(bif),
    .pwm_out(pwm_out),
    .period_tick(period_tick),
    .update_tick(update_tick),
    .dbg_state(dbg_state)
  );

  // BRAM port-B model: word at bram_addr appears on bram_dout RD_LAT cycles later
  logic [31:0] mem [0:CH_NUM];
  logic [31:0] rd_pipe [0:RD_LAT-1];
  int          rd_ai;
  always @(posedge clk25) begin
    if (bif.bram_rd_en) begin
      rd_ai = int'(bif.bram_addr) - BASE_ADDR;
      rd_pipe[0] <= (rd_ai >= 0 && rd_ai <= CH_NUM) ? mem[rd_ai] : 32'h0;
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bif.bram_dout = rd_pipe[RD_LAT-1];

  // Scoreboard
  logic [VW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {update_tick, period_tick, pwm_out} for the count the outputs reflect.
  // ch0 enabled with compare cmp0, ch1 compare 0, ch2 compare 200, ch3 disabled, others word 0.
  function automatic logic [VW-1:0] exp_vec(input int cnt, input int per, input int cmp0, input bit upd);
    logic [VW-1:0] v;
    bit act;
    for (int i = 0; i < CH_NUM; i++) begin
      case (i)
        0:       act = (cnt < cmp0);
        2:       act = (cnt < 200);
        default: act = 1'b0;
      endcase
      v[i] = ~act;
    end
    v[CH_NUM]   = (cnt == per);
    v[CH_NUM+1] = upd;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pwm"},   pwm_out, {CH_NUM{1'b1}});
    check_eq({tag, "_rden"},  bif.bram_rd_en, 1'b0);
    check_eq({tag, "_addr"},  bif.bram_addr, BASE_ADDR);
    check_eq({tag, "_ptick"}, period_tick, 1'b0);
    check_eq({tag, "_utick"}, update_tick, 1'b0);
    check_eq({tag, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic check_scan(input string tag);
    int n;
    for (int i = 0; i <= CH_NUM; i++) exp_addr_q.push_back(ADDR_W'(BASE_ADDR + i));
    n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while (!bif.bram_rd_en && n < 8);
    check_eq({tag, "_start"}, n, 1);
    for (int i = 0; i <= CH_NUM; i++) begin
      check_eq({tag, "_addr"}, bif.bram_addr, exp_addr_q.pop_front());
      check_eq({tag, "_rden"}, bif.bram_rd_en, 1'b1);
      @(negedge clk25);
    end
    check_eq({tag, "_end"}, bif.bram_rd_en, 1'b0);
  endtask

  task automatic wait_update(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while (!update_tick && n < budget);
    check_eq(tag, update_tick, 1'b1);
  endtask

  task automatic run_window(input string tag, input int n, input int chg_k, input logic [31:0] chg_word);
    logic [VW-1:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk25);
      if (k == chg_k) mem[0] = chg_word;
      e = exp_q.pop_front();
      check_eq(tag, {update_tick, period_tick, pwm_out}, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    mem[0]  = 32'h8000_0019;
    mem[1]  = 32'h8000_0000;
    mem[2]  = 32'h8000_00C8;
    mem[3]  = 32'h0000_0032;
    for (int i = 4; i < CH_NUM; i++) mem[i] = 32'h0;
    mem[CH_NUM] = 32'd99;

    repeat (5) @(posedge clk25);
    @(negedge clk25);
    check_reset_state("reset");
    fpga_rst = 1'b0;
    check_scan("scan0");

    // Duty 25/100 for two periods, ch0 moves to 60 mid-period; shadow already full so it lands one period later
    wait_update("upd_first", 400);
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 100; j++)
        exp_q.push_back(exp_vec(j, 99, (p < 2) ? 25 : 60, j == 99));
    run_window("duty", 300, 40, 32'h8000_003C);

    // Short period 3: commits only on the first wrap after each 13-cycle scan
    mem[0]      = 32'h8000_0002;
    mem[CH_NUM] = 32'd3;
    wait_update("upd_short_a", 150);
    wait_update("upd_short_b", 60);
    for (int j = 0; j < 64; j++)
      exp_q.push_back(exp_vec(j % 4, 3, 2, (j % 16) == 15));
    run_window("short", 64, -1, 32'h0);

    // Period word 0 selects a 256-cycle period
    mem[0]      = 32'h8000_0080;
    mem[CH_NUM] = 32'd0;
    wait_update("upd_p0_a", 60);
    wait_update("upd_p0_b", 300);
    for (int j = 0; j < 256; j++)
      exp_q.push_back(exp_vec(j, 255, 128, j == 255));
    run_window("per0", 256, -1, 32'h0);

    // Reset in the middle of a scan
    found = 0;
    for (int n = 0; n < 600 && found == 0; n++) begin
      @(negedge clk25);
      if (bif.bram_rd_en && bif.bram_addr == ADDR_W'(BASE_ADDR + 4)) found = 1;
    end
    check_eq("midrst_trigger", found, 1);
    fpga_rst = 1'b1;
    @(negedge clk25);
    check_reset_state("midrst");
    fpga_rst = 1'b0;
    check_scan("scan1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
